// File: rtl/fetch_unit_if.sv
// Signal bundle between the fetch unit and its surroundings: instruction-memory
// port, backend redirect and the decode-side valid/ready handshake.
interface fetch_unit_if #(
    parameter int unsigned DEPTH = 4
) ();
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic              imem_read;
    logic [31:0]       imem_addr;
    logic              imem_resp;
    logic [31:0]       imem_rdata;

    logic              redirect;
    logic [31:0]       redirect_pc;

    logic              dec_valid;
    logic              dec_ready;
    logic [31:0]       dec_instr;
    logic [31:0]       dec_pc;
    logic [OCC_W-1:0]  occupancy;

    // The fetch unit drives requests and the decode head.
    modport master (
        output imem_read, imem_addr, dec_valid, dec_instr, dec_pc, occupancy,
        input  imem_resp, imem_rdata, redirect, redirect_pc, dec_ready
    );

    // Memory, backend and decode stage seen as one environment.
    modport slave (
        input  imem_read, imem_addr, dec_valid, dec_instr, dec_pc, occupancy,
        output imem_resp, imem_rdata, redirect, redirect_pc, dec_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding word read, a small PC-tagged FIFO towards
// decode, and flush/restart on backend redirects.
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL      = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] LAST_FREE = OCC_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SQUASH
    } state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             imem_read_q, imem_read_d;
    logic [31:0]      imem_addr_q, imem_addr_d;

    entry_t           mem_q [DEPTH];
    entry_t           mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             dec_valid_q, dec_valid_d;
    entry_t           head_q, head_d;

    logic             push;
    logic             pop;
    logic [31:0]      redirect_target;

    assign redirect_target = bus.redirect_pc & 32'hFFFF_FFFC;

    // Request FSM. Credit checks use occupancy before this cycle's pop, so a
    // request is only ever issued when its returning word already has a slot.
    always_comb begin
        // NOTE: every comb output gets a default first so no path infers a latch.
        state_d     = state_q;
        pc_d        = pc_q;
        imem_read_d = imem_read_q;
        imem_addr_d = imem_addr_q;
        push        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    pc_d = redirect_target;
                end
                if (bus.redirect || (count_q < FULL)) begin
                    state_d     = REQ;
                    imem_read_d = 1'b1;
                    imem_addr_d = pc_d;
                end
            end

            REQ: begin
                if (bus.redirect) begin
                    pc_d = redirect_target;
                    if (bus.imem_resp) begin
                        imem_addr_d = redirect_target;
                    end else begin
                        state_d = SQUASH;
                    end
                end else if (bus.imem_resp) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                    if (count_q < LAST_FREE) begin
                        imem_addr_d = pc_d;
                    end else begin
                        state_d     = IDLE;
                        imem_read_d = 1'b0;
                    end
                end
            end

            SQUASH: begin
                // The stale request stays on the bus until memory answers it.
                if (bus.redirect) begin
                    pc_d = redirect_target;
                end
                if (bus.imem_resp) begin
                    state_d     = REQ;
                    imem_addr_d = pc_d;
                end
            end

            default: begin
                state_d     = IDLE;
                imem_read_d = 1'b0;
            end
        endcase
    end

    // FIFO bookkeeping; the next head is precomputed so decode sees flops only.
    always_comb begin
        pop      = dec_valid_q & bus.dec_ready & ~bus.redirect;
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (bus.redirect) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc: pc_q, instr: bus.imem_rdata};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end

        dec_valid_d = (count_d != '0);
        head_d      = dec_valid_d ? mem_d[rd_ptr_d] : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            imem_read_q <= 1'b0;
            imem_addr_q <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            dec_valid_q <= 1'b0;
            head_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imem_read_q <= imem_read_d;
            imem_addr_q <= imem_addr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            dec_valid_q <= dec_valid_d;
            head_q      <= head_d;
        end
    end

    // NOTE: the storage array is not reset; a slot is only read after a push, and head_q is cleared on reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.imem_read = imem_read_q;
    assign bus.imem_addr = imem_addr_q;
    assign bus.dec_valid = dec_valid_q;
    assign bus.dec_instr = head_q.instr;
    assign bus.dec_pc    = head_q.pc;
    assign bus.occupancy = count_q;

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= FULL);

    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (imem_read_q && !bus.imem_resp) |=> $stable(imem_addr_q));

endmodule
